control_ajuste_reloj: RTL

//  Edit/run controller for the calendar-clock digit chain (centesimas..year).

---
 rtl/control_ajuste_reloj_if.sv | 39 +++
 rtl/control_ajuste_reloj.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_ajuste_reloj_if.sv
// ---------------------------------------------------------------------------
// control_ajuste_reloj_if
// Groups the button/time-base inputs and the edit-control outputs of the
// calendar-clock edit/run controller.
//
// Signals
//   tick       button side -> controller  one-clk centisecond strobe
//   btn_mode   button side -> controller  debounced level, advance edit field
//   btn_inc    button side -> controller  debounced level, increment field
//   btn_exit   button side -> controller  debounced level, return to run
//   stay       controller -> digit chain  run enable, 1 only in RUN
//   add_field  controller -> digit chain  one-hot inc pulse [0]min..[4]year
//   edit_sel   controller -> display      0 RUN, 1 MIN .. 5 YEAR
//   blink      controller -> display      blink phase for selected field
//
// Modports
//   master  drives tick and buttons, observes the controller outputs
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface control_ajuste_reloj_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_exit;
    logic       stay;
    logic [4:0] add_field;
    logic [2:0] edit_sel;
    logic       blink;

    modport master (
        output tick, btn_mode, btn_inc, btn_exit,
        input  stay, add_field, edit_sel, blink
    );

    modport slave (
        input  tick, btn_mode, btn_inc, btn_exit,
        output stay, add_field, edit_sel, blink
    );
endinterface

// File: rtl/control_ajuste_reloj.sv
// ---------------------------------------------------------------------------
// control_ajuste_reloj
// Edit/run controller for the calendar-clock digit chain. Gates the chain's
// run enable, selects the field under edit and issues single-clock increment
// pulses to that field only. Range and carry checks live in the digit modules.
//
// Ports
//   clk   system clock, single domain
//   rst   synchronous reset, active-low (0 = reset)
//   bus   control_ajuste_reloj_if.slave (tick, buttons in; stay, add_field,
//         edit_sel, blink out)
//
// Build option
//   AUTOREPEAT_EN  when defined, holding btn_inc in a set state auto-repeats:
//                  first repeat after HOLD_TICKS ticks, then every
//                  REPEAT_TICKS ticks. When undefined only the rising edge
//                  of btn_inc produces a pulse.
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | clock running, stay=1, no field selected
// MIN   | editing minutes, add_field[0]
// HOUR  | editing hours,   add_field[1]
// DAY   | editing day,     add_field[2]
// MON   | editing month,   add_field[3]
// YEAR  | editing year,    add_field[4]
// ---------------------------------------------------------------------------
module control_ajuste_reloj #(
    parameter int CNT_W         = 10,
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 20,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int BLINK_TICKS   = 25
) (
    input logic                  clk,
    input logic                  rst,
    control_ajuste_reloj_if.slave bus
);

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        MIN  = 3'd1,
        HOUR = 3'd2,
        DAY  = 3'd3,
        MON  = 3'd4,
        YEAR = 3'd5
    } stateT;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_TICKS - 1);

    // Counters compare with == and never wrap, so every terminal value has
    // to be representable in CNT_W bits.
    if (HOLD_TICKS < 1 || REPEAT_TICKS < 1 || BLINK_TICKS < 1 ||
        TIMEOUT_TICKS < 1 || TIMEOUT_TICKS >= (2 ** CNT_W) ||
        HOLD_TICKS > (2 ** CNT_W) || REPEAT_TICKS > (2 ** CNT_W) ||
        BLINK_TICKS > (2 ** CNT_W)) begin : gBadParams
        $error("control_ajuste_reloj: tick parameter out of range for CNT_W");
    end

    stateT            state;
    stateT            nextState;

    logic             btnModeCur, btnModePrev;
    logic             btnIncCur,  btnIncPrev;
    logic             btnExitCur, btnExitPrev;
    logic             modeEdge, incEdge, exitEdge;

    logic [CNT_W-1:0] toCnt;
    logic [CNT_W-1:0] blinkCnt;
    logic             inSet;
    logic             timeoutHit;
    logic             stateChange;
    logic             repeatFire;

    logic             stayQ, stayNext;
    logic [4:0]       addQ, addNext;
    logic             blinkQ;

    assign modeEdge    = btnModeCur & ~btnModePrev;
    assign incEdge     = btnIncCur  & ~btnIncPrev;
    assign exitEdge    = btnExitCur & ~btnExitPrev;
    assign inSet       = (state != RUN);
    assign timeoutHit  = inSet && (toCnt == TIMEOUT_END);
    assign stateChange = (nextState != state);

    // ---------------------------------------------------------------
    // Button history: one register stage, then a previous-value copy.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            btnModeCur  <= 1'b0;
            btnModePrev <= 1'b0;
            btnIncCur   <= 1'b0;
            btnIncPrev  <= 1'b0;
            btnExitCur  <= 1'b0;
            btnExitPrev <= 1'b0;
        end else begin
            btnModeCur  <= bus.btn_mode;
            btnModePrev <= btnModeCur;
            btnIncCur   <= bus.btn_inc;
            btnIncPrev  <= btnIncCur;
            btnExitCur  <= bus.btn_exit;
            btnExitPrev <= btnExitCur;
        end
    end

    // ---------------------------------------------------------------
    // Auto-repeat hold counter
    // ---------------------------------------------------------------
`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    logic [CNT_W-1:0] holdCnt;
    logic             repeating;

    // repeating=0 measures the initial hold delay, repeating=1 the
    // interval between subsequent repeats; the counter restarts at each.
    assign repeatFire = inSet && btnIncCur && bus.tick &&
                        (repeating ? (holdCnt == REPEAT_LAST)
                                   : (holdCnt == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (!rst) begin
            holdCnt   <= '0;
            repeating <= 1'b0;
        end else if (!inSet || !btnIncCur || stateChange) begin
            holdCnt   <= '0;
            repeating <= 1'b0;
        end else if (bus.tick) begin
            if (repeatFire) begin
                holdCnt   <= '0;
                repeating <= 1'b1;
            end else begin
                holdCnt   <= holdCnt + CNT_ONE;
            end
        end
    end
`else
    assign repeatFire = 1'b0;
`endif

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state. Priority exit > mode > inc; a lower-priority edge
    // arriving in the same cycle is dropped. An increment (edge or repeat)
    // in the timeout cycle restarts the count instead of leaving set mode.
    // ---------------------------------------------------------------
    always_comb begin
        nextState = state;
        if (state == RUN) begin
            if (modeEdge && !exitEdge) begin
                nextState = MIN;
            end
        end else if (exitEdge) begin
            nextState = RUN;
        end else if (modeEdge) begin
            nextState = (state == YEAR) ? RUN : stateT'(state + 3'd1);
        end else if (timeoutHit && !incEdge && !repeatFire) begin
            nextState = RUN;
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs, computed from the transition so they register in
    // the same edge as the state. No increment on a state change.
    // ---------------------------------------------------------------
    always_comb begin
        stayNext = (nextState == RUN);
        addNext  = 5'b00000;
        if (inSet && !stateChange && (incEdge || repeatFire)) begin
            addNext = 5'b00001 << (state - 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stayQ <= 1'b0;
            addQ  <= 5'b00000;
        end else begin
            stayQ <= stayNext;
            addQ  <= addNext;
        end
    end

    // ---------------------------------------------------------------
    // Inactivity timeout: saturates at TIMEOUT_TICKS, restarts on any
    // button edge, on repeat pulses and on entering a state.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            toCnt <= '0;
        end else if (!inSet || stateChange || modeEdge || incEdge ||
                     exitEdge || repeatFire) begin
            toCnt <= '0;
        end else if (bus.tick && (toCnt != TIMEOUT_END)) begin
            toCnt <= toCnt + CNT_ONE;
        end
    end

    // ---------------------------------------------------------------
    // Blink: starts visible on entry to every set state, toggles each
    // BLINK_TICKS ticks, held off in RUN.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            blinkQ   <= 1'b0;
            blinkCnt <= '0;
        end else if (nextState == RUN) begin
            blinkQ   <= 1'b0;
            blinkCnt <= '0;
        end else if (stateChange) begin
            blinkQ   <= 1'b1;
            blinkCnt <= '0;
        end else if (bus.tick) begin
            if (blinkCnt == BLINK_LAST) begin
                blinkQ   <= ~blinkQ;
                blinkCnt <= '0;
            end else begin
                blinkCnt <= blinkCnt + CNT_ONE;
            end
        end
    end

    assign bus.stay      = stayQ;
    assign bus.add_field = addQ;
    assign bus.edit_sel  = state;
    assign bus.blink     = blinkQ;

endmodule
